wb_merge: RTL and testbench

- Writeback-port merger that sits directly upstream of the register file and drives its single write port (wr_en, dest_addr, wr_data).
- Merges two result sources:
  - the in-order pipeline writeback, which has fixed priority and can never stall;
  - results from the multi-cycle divide unit, buffered in a small FIFO and drained into idle writeback slots.
- Keeps a pending-destination scoreboard so the hazard unit can stall readers of registers that still await a divide result.

---
 rtl/wb_merge.sv | 177 +++++++++++++++++
 tb/tb_wb_merge.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/wb_merge.sv
// ----------------------------------------------------------------------------
// wb_merge
//
// Drives the register file's single write port from two result sources:
//   - the in-order pipeline writeback (fixed priority, never stalls), and
//   - the multi-cycle divide unit, whose results are buffered in a small FIFO
//     and drained into writeback slots the pipeline leaves idle.
// A pending-destination scoreboard tracks registers still awaiting a divide
// result so the hazard unit can stall their readers.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   wb_en, wb_rd, wb_data     pipeline writeback
//   div_issue, div_issue_rd   divide issued (marks destination pending)
//   div_valid, div_rd,
//   div_data, div_ready       divide result handshake
//   rf_wr_en, rf_dest_addr,
//   rf_wr_data                registered regfile write port (1-cycle latency)
//   pend_mask                 bit i set: x_i awaits a divide result
//   fifo_cnt                  FIFO occupancy (debug)
// ----------------------------------------------------------------------------
module wb_merge #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wb_en,
  input  logic [4:0]                   wb_rd,
  input  logic [XLEN-1:0]              wb_data,
  input  logic                         div_issue,
  input  logic [4:0]                   div_issue_rd,
  input  logic                         div_valid,
  input  logic [4:0]                   div_rd,
  input  logic [XLEN-1:0]              div_data,
  output logic                         div_ready,
  output logic                         rf_wr_en,
  output logic [4:0]                   rf_dest_addr,
  output logic [XLEN-1:0]              rf_wr_data,
  output logic [31:0]                  pend_mask,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_cnt
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  // FIFO storage and pointers; pointers wrap naturally since DEPTH is 2^PW.
  logic [4:0]      r_fifo_rd   [DEPTH];
  logic [XLEN-1:0] r_fifo_data [DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_cnt;

  logic            r_wr_en;
  logic [4:0]      r_dest_addr;
  logic [XLEN-1:0] r_wr_data;
  logic [31:0]     r_pend;

  logic            w_pipe_slot;
  logic            w_div_push;
  logic            w_fifo_empty;
  logic [4:0]      w_head_rd;
  logic [XLEN-1:0] w_head_data;
  logic            w_pop;
  logic            w_bypass;
  logic            w_push;

  logic            w_wr_en_nxt;
  logic [4:0]      w_dest_addr_nxt;
  logic [XLEN-1:0] w_wr_data_nxt;
  logic            w_clr_en;
  logic [4:0]      w_clr_rd;
  logic [31:0]     w_pend_nxt;
  logic [CW-1:0]   w_cnt_nxt;

  // Ready depends on occupancy only, never on the pipeline writeback.
  assign div_ready = !rst && (r_cnt < CW'(DEPTH));

  assign w_pipe_slot  = wb_en && (wb_rd != 5'd0);
  assign w_div_push   = div_valid && div_ready;
  assign w_fifo_empty = (r_cnt == '0);
  assign w_head_rd    = r_fifo_rd[r_rptr];
  assign w_head_data  = r_fifo_data[r_rptr];
  assign w_pop        = !w_pipe_slot && !w_fifo_empty;
  // An empty FIFO with a free slot forwards the incoming result directly.
  assign w_bypass     = !w_pipe_slot && w_fifo_empty && w_div_push;
  assign w_push       = w_div_push && !w_bypass;

  // Output-register next state, in priority order.
  always_comb begin
    w_wr_en_nxt     = 1'b0;
    w_dest_addr_nxt = r_dest_addr;
    w_wr_data_nxt   = r_wr_data;
    w_clr_en        = 1'b0;
    w_clr_rd        = 5'd0;
    if (w_pipe_slot) begin
      w_wr_en_nxt     = 1'b1;
      w_dest_addr_nxt = wb_rd;
      w_wr_data_nxt   = wb_data;
    end else if (w_pop) begin
      // A head entry for x0 is popped and discarded; address/data hold.
      if (w_head_rd != 5'd0) begin
        w_wr_en_nxt     = 1'b1;
        w_dest_addr_nxt = w_head_rd;
        w_wr_data_nxt   = w_head_data;
        w_clr_en        = 1'b1;
        w_clr_rd        = w_head_rd;
      end
    end else if (w_bypass) begin
      w_wr_en_nxt     = (div_rd != 5'd0);
      w_dest_addr_nxt = div_rd;
      w_wr_data_nxt   = div_data;
      w_clr_en        = 1'b1;
      w_clr_rd        = div_rd;
    end
  end

  // Scoreboard: clear first so a same-cycle issue to the same rd wins.
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_clr_en) begin
      w_pend_nxt[w_clr_rd] = 1'b0;
    end
    if (div_issue && (div_issue_rd != 5'd0)) begin
      w_pend_nxt[div_issue_rd] = 1'b1;
    end
    w_pend_nxt[0] = 1'b0;
  end

  always_comb begin
    w_cnt_nxt = r_cnt;
    unique case ({w_push, w_pop})
      2'b10:   w_cnt_nxt = r_cnt + CW'(1);
      2'b01:   w_cnt_nxt = r_cnt - CW'(1);
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_cnt       <= '0;
      r_wr_en     <= 1'b0;
      r_dest_addr <= 5'd0;
      r_wr_data   <= '0;
      r_pend      <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      r_cnt       <= w_cnt_nxt;
      r_wr_en     <= w_wr_en_nxt;
      r_dest_addr <= w_dest_addr_nxt;
      r_wr_data   <= w_wr_data_nxt;
      r_pend      <= w_pend_nxt;
    end
  end

  // Storage needs no reset; occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_rd[r_wptr]   <= div_rd;
      r_fifo_data[r_wptr] <= div_data;
    end
  end

  assign rf_wr_en     = r_wr_en;
  assign rf_dest_addr = r_dest_addr;
  assign rf_wr_data   = r_wr_data;
  assign pend_mask    = r_pend;
  assign fifo_cnt     = r_cnt;

endmodule

// File: tb/tb_wb_merge.sv
// ----------------------------------------------------------------------------
// tb_wb_merge: directed self-checking bench for wb_merge (DEPTH=4, XLEN=32).
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
// ----------------------------------------------------------------------------
module tb_wb_merge;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        div_issue;
  logic [4:0]  div_issue_rd;
  logic        div_valid;
  logic [4:0]  div_rd;
  logic [31:0] div_data;
  logic        div_ready;
  logic        rf_wr_en;
  logic [4:0]  rf_dest_addr;
  logic [31:0] rf_wr_data;
  logic [31:0] pend_mask;
  logic [2:0]  fifo_cnt;

  int n_vec = 0;
  int n_err = 0;

  wb_merge #(.DEPTH(4), .XLEN(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .wb_en        (wb_en),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .div_issue    (div_issue),
    .div_issue_rd (div_issue_rd),
    .div_valid    (div_valid),
    .div_rd       (div_rd),
    .div_data     (div_data),
    .div_ready    (div_ready),
    .rf_wr_en     (rf_wr_en),
    .rf_dest_addr (rf_dest_addr),
    .rf_wr_data   (rf_wr_data),
    .pend_mask    (pend_mask),
    .fifo_cnt     (fifo_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; wb_en = 1'b1; wb_rd = 5'd3; wb_data = 32'hFFFF_0003;
    tick(); tick();
    n_vec++; if (rf_wr_en !== 1'b0) begin n_err++; $display("FAIL reset_wr_en got %b want 0", rf_wr_en); end
    n_vec++; if (pend_mask !== 32'h0) begin n_err++; $display("FAIL reset_pend got %h want 0", pend_mask); end
    n_vec++; if (fifo_cnt !== 3'd0) begin n_err++; $display("FAIL reset_cnt got %0d want 0", fifo_cnt); end
    n_vec++; if (rf_dest_addr !== 5'd0) begin n_err++; $display("FAIL reset_addr got %0d want 0", rf_dest_addr); end
    n_vec++; if (div_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b want 0", div_ready); end
    rst = 1'b0; wb_en = 1'b0;
    #1;
    n_vec++; if (div_ready !== 1'b1) begin n_err++; $display("FAIL release_ready got %b want 1", div_ready); end
  endtask

  task automatic test_bypass();
    div_valid = 1'b1; div_rd = 5'd5; div_data = 32'h0000_1234;
    tick();
    div_valid = 1'b0;
    n_vec++; if (rf_wr_en !== 1'b1) begin n_err++; $display("FAIL bypass_wr_en got %b want 1", rf_wr_en); end
    n_vec++; if (rf_dest_addr !== 5'd5) begin n_err++; $display("FAIL bypass_addr got %0d want 5", rf_dest_addr); end
    n_vec++; if (rf_wr_data !== 32'h0000_1234) begin n_err++; $display("FAIL bypass_data got %h want 00001234", rf_wr_data); end
    n_vec++; if (fifo_cnt !== 3'd0) begin n_err++; $display("FAIL bypass_cnt got %0d want 0", fifo_cnt); end
    tick();
    n_vec++; if (rf_wr_en !== 1'b0) begin n_err++; $display("FAIL bypass_idle got %b want 0", rf_wr_en); end
  endtask

  task automatic test_contention();
    logic [2:0] exp_cnt;
    logic [4:0] exp_rd;
    int         drain_cnt [5] = '{3, 3, 2, 1, 0};
    wb_en = 1'b1; wb_rd = 5'd3; wb_data = 32'hAAAA_0003;
    for (int k = 0; k < 5; k++) begin
      div_valid = 1'b1; div_rd = 5'(6 + k); div_data = 32'hD000_0000 + 32'(6 + k);
      #1;
      n_vec++; if (div_ready !== (k < 4)) begin n_err++; $display("FAIL cont_ready[%0d] got %b want %b", k, div_ready, (k < 4)); end
      tick();
      exp_cnt = (k < 4) ? 3'(k + 1) : 3'd4;
      n_vec++; if (rf_wr_en !== 1'b1 || rf_dest_addr !== 5'd3 || rf_wr_data !== 32'hAAAA_0003) begin
        n_err++; $display("FAIL cont_pipe[%0d] got en=%b rd=%0d data=%h want en=1 rd=3 data=aaaa0003", k, rf_wr_en, rf_dest_addr, rf_wr_data); end
      n_vec++; if (fifo_cnt !== exp_cnt) begin n_err++; $display("FAIL cont_cnt[%0d] got %0d want %0d", k, fifo_cnt, exp_cnt); end
    end
    // x10 is still held by the producer; the pipeline goes idle.
    wb_en = 1'b0;
    for (int j = 0; j < 5; j++) begin
      tick();
      exp_rd = 5'(6 + j);
      if (j == 1) div_valid = 1'b0;
      n_vec++; if (rf_wr_en !== 1'b1 || rf_dest_addr !== exp_rd || rf_wr_data !== 32'hD000_0000 + 32'(6 + j)) begin
        n_err++; $display("FAIL drain[%0d] got en=%b rd=%0d data=%h want en=1 rd=%0d", j, rf_wr_en, rf_dest_addr, rf_wr_data, exp_rd); end
      n_vec++; if (fifo_cnt !== 3'(drain_cnt[j])) begin n_err++; $display("FAIL drain_cnt[%0d] got %0d want %0d", j, fifo_cnt, drain_cnt[j]); end
      if (j == 0) begin
        n_vec++; if (div_ready !== 1'b1) begin n_err++; $display("FAIL drain_ready got %b want 1", div_ready); end
      end
    end
    tick();
    n_vec++; if (rf_wr_en !== 1'b0 || rf_dest_addr !== 5'd10) begin
      n_err++; $display("FAIL drain_end got en=%b rd=%0d want en=0 rd=10", rf_wr_en, rf_dest_addr); end
  endtask

  task automatic test_scoreboard();
    div_issue = 1'b1; div_issue_rd = 5'd7;
    tick();
    div_issue = 1'b0;
    n_vec++; if (pend_mask !== 32'h80) begin n_err++; $display("FAIL sb_set got %h want 00000080", pend_mask); end
    // Pipeline write to x7 must not clear the pending bit.
    wb_en = 1'b1; wb_rd = 5'd7; wb_data = 32'h7777_0000;
    tick();
    wb_en = 1'b0;
    n_vec++; if (pend_mask !== 32'h80) begin n_err++; $display("FAIL sb_pipe got %h want 00000080", pend_mask); end
    // Result for x7 loads while a new divide to x7 issues: set wins.
    div_valid = 1'b1; div_rd = 5'd7; div_data = 32'h0000_0707;
    div_issue = 1'b1; div_issue_rd = 5'd7;
    tick();
    div_issue = 1'b0;
    n_vec++; if (pend_mask !== 32'h80) begin n_err++; $display("FAIL sb_setwins got %h want 00000080", pend_mask); end
    n_vec++; if (rf_wr_en !== 1'b1 || rf_dest_addr !== 5'd7 || rf_wr_data !== 32'h0000_0707) begin
      n_err++; $display("FAIL sb_load got en=%b rd=%0d data=%h want en=1 rd=7 data=00000707", rf_wr_en, rf_dest_addr, rf_wr_data); end
    div_data = 32'h0000_0708;
    tick();
    div_valid = 1'b0;
    n_vec++; if (pend_mask !== 32'h0) begin n_err++; $display("FAIL sb_clear got %h want 0", pend_mask); end
    // Issue to x0 never sets bit 0.
    div_issue = 1'b1; div_issue_rd = 5'd0;
    tick();
    div_issue = 1'b0;
    n_vec++; if (pend_mask !== 32'h0) begin n_err++; $display("FAIL sb_x0 got %h want 0", pend_mask); end
  endtask

  task automatic test_x0();
    // Busy pipeline forces the x0 result into the FIFO.
    wb_en = 1'b1; wb_rd = 5'd3; wb_data = 32'h3333_3333;
    div_valid = 1'b1; div_rd = 5'd0; div_data = 32'hBAD0_0000;
    tick();
    div_valid = 1'b0;
    n_vec++; if (fifo_cnt !== 3'd1) begin n_err++; $display("FAIL x0_push got %0d want 1", fifo_cnt); end
    wb_rd = 5'd0;
    tick();
    n_vec++; if (rf_wr_en !== 1'b0) begin n_err++; $display("FAIL x0_drop got %b want 0", rf_wr_en); end
    n_vec++; if (fifo_cnt !== 3'd0) begin n_err++; $display("FAIL x0_pop got %0d want 0", fifo_cnt); end
    n_vec++; if (rf_wr_data !== 32'h3333_3333) begin n_err++; $display("FAIL x0_hold got %h want 33333333", rf_wr_data); end
    tick();
    n_vec++; if (rf_wr_en !== 1'b0) begin n_err++; $display("FAIL x0_pipe got %b want 0", rf_wr_en); end
    wb_en = 1'b0;
    div_valid = 1'b1; div_rd = 5'd0; div_data = 32'hBAD0_0001;
    tick();
    div_valid = 1'b0;
    n_vec++; if (rf_wr_en !== 1'b0 || fifo_cnt !== 3'd0) begin
      n_err++; $display("FAIL x0_bypass got en=%b cnt=%0d want en=0 cnt=0", rf_wr_en, fifo_cnt); end
  endtask

  task automatic test_mid_reset();
    wb_en = 1'b1; wb_rd = 5'd3; wb_data = 32'h3000_0000;
    for (int k = 0; k < 4; k++) begin
      div_issue = 1'b1; div_issue_rd = 5'(4 + k);
      div_valid = (k < 3); div_rd = 5'(11 + k); div_data = 32'hC000_0000 + 32'(k);
      tick();
    end
    div_issue = 1'b0; div_valid = 1'b0;
    n_vec++; if (fifo_cnt !== 3'd3) begin n_err++; $display("FAIL mr_fill got %0d want 3", fifo_cnt); end
    n_vec++; if (pend_mask !== 32'h0F0) begin n_err++; $display("FAIL mr_pend got %h want 000000f0", pend_mask); end
    wb_en = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    n_vec++; if (fifo_cnt !== 3'd0 || pend_mask !== 32'h0 || rf_wr_en !== 1'b0) begin
      n_err++; $display("FAIL mr_clear got cnt=%0d pend=%h en=%b want 0", fifo_cnt, pend_mask, rf_wr_en); end
    for (int j = 0; j < 3; j++) begin
      tick();
      n_vec++; if (rf_wr_en !== 1'b0 || fifo_cnt !== 3'd0) begin
        n_err++; $display("FAIL mr_stale[%0d] got en=%b cnt=%0d want 0", j, rf_wr_en, fifo_cnt); end
    end
  endtask

  initial begin
    rst = 1'b1; wb_en = 1'b0; wb_rd = 5'd0; wb_data = '0;
    div_issue = 1'b0; div_issue_rd = 5'd0;
    div_valid = 1'b0; div_rd = 5'd0; div_data = '0;
    test_reset();
    test_bypass();
    test_contention();
    test_scoreboard();
    test_x0();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
